// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer driven by the shared one-cycle enable tick.
// Counts a loaded value down to 00:00 and either stops (expired) or, with
// RELOAD=1, restarts from the last loaded value without ever showing 00:00.
module bcd_countdown_timer #(
   parameter int PRESCALE = 1,   // enable pulses per one-second step, >= 1
   parameter bit RELOAD   = 1'b0 // 1: auto-reload at expiry and keep running
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        start,
   input  logic        pause,
   output logic [15:0] count,
   output logic        running,
   output logic        expired,
   output logic        done,
   output logic        load_error
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] PAUSED = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   // A PRESCALE of 1 still gets a 1-bit prescaler that simply stays at 0.
   localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

   logic [1:0]    state;
   logic [PW-1:0] prescaler;
   logic [15:0]   reload_reg;
   logic          load_ok;
   logic [15:0]   count_dec;

   // Load is legal only if every digit is decimal and both tens digits are <= 5.
   always_comb begin
      load_ok = (load_value[3:0]   <= 4'd9) &&
                (load_value[7:4]   <= 4'd5) &&
                (load_value[11:8]  <= 4'd9) &&
                (load_value[15:12] <= 4'd5);
   end

   // One-second BCD decrement with the sec_o -> sec_t -> min_o -> min_t borrow chain.
   always_comb begin
      count_dec = count;
      if (count[3:0] != 4'd0) begin
         count_dec[3:0] = count[3:0] - 4'd1;
      end else begin
         count_dec[3:0] = 4'd9;
         if (count[7:4] != 4'd0) begin
            count_dec[7:4] = count[7:4] - 4'd1;
         end else begin
            count_dec[7:4] = 4'd5;
            if (count[11:8] != 4'd0) begin
               count_dec[11:8] = count[11:8] - 4'd1;
            end else begin
               count_dec[11:8]  = 4'd9;
               count_dec[15:12] = count[15:12] - 4'd1;
            end
         end
      end
   end

   // State, count and pulse flags; priority is reset > load > pause > start > tick.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         count      <= 16'h0000;
         prescaler  <= '0;
         reload_reg <= 16'h0000;
         done       <= 1'b0;
         load_error <= 1'b0;
      end else begin
         done       <= 1'b0;
         load_error <= 1'b0;
         if (load) begin
            // A rejected load leaves every register alone; it only flags the error.
            if (load_ok) begin
               count      <= load_value;
               reload_reg <= load_value;
               state      <= IDLE;
               prescaler  <= '0;
            end else begin
               load_error <= 1'b1;
            end
         end else if (pause) begin
            if (state == RUN) state <= PAUSED;
         end else if (start) begin
            if (state == IDLE && count != 16'h0000) begin
               state     <= RUN;
               prescaler <= '0;
            end else if (state == PAUSED) begin
               state <= RUN;  // resume keeps the partial prescale count
            end
         end else if (enable && state == RUN) begin
            if (prescaler == PS_LAST) begin
               prescaler <= '0;
               if (count == 16'h0001) begin
                  done <= 1'b1;
                  if (RELOAD) begin
                     count <= reload_reg;  // skip 00:00 so the period is exactly reload_reg
                  end else begin
                     count <= 16'h0000;
                     state <= DONE;
                  end
               end else begin
                  count <= count_dec;
               end
            end else begin
               prescaler <= prescaler + PW'(1);
            end
         end
      end
   end

   assign running = (state == RUN);
   assign expired = (state == DONE);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer. Three instances cover the
// PRESCALE=1/RELOAD=0, PRESCALE=4 and RELOAD=1 configurations. Stimulus pushes
// the expected output snapshot (and the cycle it must appear on) for every
// output change; the monitor pops one entry whenever a DUT's outputs change.
module tb_bcd_countdown_timer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [2:0]       rst = 3'b111;
   logic [2:0]       enable = '0, load = '0, start = '0, pause = '0;
   logic [2:0][15:0] load_value = '0;
   logic [2:0][15:0] count;
   logic [2:0]       running, expired, done, load_error;

   bcd_countdown_timer #(.PRESCALE(1), .RELOAD(1'b0)) u0 (
      .clock(clock), .reset(rst[0]), .enable(enable[0]), .load(load[0]),
      .load_value(load_value[0]), .start(start[0]), .pause(pause[0]),
      .count(count[0]), .running(running[0]), .expired(expired[0]),
      .done(done[0]), .load_error(load_error[0]));

   bcd_countdown_timer #(.PRESCALE(4), .RELOAD(1'b0)) u1 (
      .clock(clock), .reset(rst[1]), .enable(enable[1]), .load(load[1]),
      .load_value(load_value[1]), .start(start[1]), .pause(pause[1]),
      .count(count[1]), .running(running[1]), .expired(expired[1]),
      .done(done[1]), .load_error(load_error[1]));

   bcd_countdown_timer #(.PRESCALE(1), .RELOAD(1'b1)) u2 (
      .clock(clock), .reset(rst[2]), .enable(enable[2]), .load(load[2]),
      .load_value(load_value[2]), .start(start[2]), .pause(pause[2]),
      .count(count[2]), .running(running[2]), .expired(expired[2]),
      .done(done[2]), .load_error(load_error[2]));

   typedef struct {
      int          dut;
      logic [15:0] cnt;
      logic        run, xp, dn, le;
      int          at;   // required cycle, -1 = any
      string       name;
   } exp_t;

   exp_t q[$];
   int   compared = 0, mismatched = 0;
   int   cycle = 0;
   logic [2:0] arm = '0;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic expect_ev(input int d, input logic [15:0] c, input logic r, input logic x,
                            input logic dn, input logic le, input int dly, input string nm);
      exp_t e;
      e.dut = d; e.cnt = c; e.run = r; e.xp = x; e.dn = dn; e.le = le;
      e.at = (dly == 0) ? -1 : cycle + dly;
      e.name = nm;
      q.push_back(e);
   endtask

   task automatic drv(input int d, input logic ld, input logic [15:0] lv,
                      input logic st, input logic pa, input logic en);
      load[d] = ld; load_value[d] = lv; start[d] = st; pause[d] = pa; enable[d] = en;
      @(posedge clock); #1;
      load[d] = 1'b0; start[d] = 1'b0; pause[d] = 1'b0; enable[d] = 1'b0;
   endtask

   task automatic idle(input int d, input int n);
      for (int i = 0; i < n; i++) drv(d, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int m, x;
      m = s / 60; x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   // Monitor: any change of a DUT's output snapshot is one event to score.
   initial begin
      logic [2:0][19:0] prev;
      logic [2:0]       seen;
      seen = '0;
      prev = '0;
      forever begin
         @(negedge clock);
         for (int d = 0; d < 3; d++) begin
            logic [19:0] snap;
            snap = {count[d], running[d], expired[d], done[d], load_error[d]};
            if ((arm[d] && !seen[d]) || (seen[d] && snap !== prev[d])) begin
               compared++;
               if (q.size() == 0) begin
                  mismatched++;
                  $display("FAIL unexpected_event: dut%0d cnt=%h run=%b exp=%b done=%b lerr=%b @%0d, none queued",
                           d, count[d], running[d], expired[d], done[d], load_error[d], cycle);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  if (e.dut != d || snap !== {e.cnt, e.run, e.xp, e.dn, e.le} ||
                      (e.at >= 0 && e.at != cycle)) begin
                     mismatched++;
                     $display("FAIL %s: got dut%0d cnt=%h run=%b exp=%b done=%b lerr=%b @%0d, want dut%0d cnt=%h run=%b exp=%b done=%b lerr=%b @%0d",
                              e.name, d, count[d], running[d], expired[d], done[d], load_error[d], cycle,
                              e.dut, e.cnt, e.run, e.xp, e.dn, e.le, e.at);
                  end
               end
               seen[d] = 1'b1;
            end
            prev[d] = snap;
         end
      end
   end

   // Directed stimulus with hand-derived expectations.
   initial begin
      repeat (2) @(posedge clock);
      #1;
      rst = '0;
      for (int d = 0; d < 3; d++) expect_ev(d, 16'h0000, 0, 0, 0, 0, 0, "reset_state");
      arm = 3'b111;
      idle(0, 2);

      // ---- basic countdown, dut0 ----
      expect_ev(0, 16'h0003, 0, 0, 0, 0, 1, "basic_load");
      drv(0, 1, 16'h0003, 0, 0, 0);
      expect_ev(0, 16'h0003, 1, 0, 0, 0, 1, "basic_start");
      drv(0, 0, 16'h0, 1, 0, 0);
      expect_ev(0, 16'h0002, 1, 0, 0, 0, 1, "basic_t1");
      drv(0, 0, 16'h0, 0, 0, 1);
      expect_ev(0, 16'h0001, 1, 0, 0, 0, 1, "basic_t2");
      drv(0, 0, 16'h0, 0, 0, 1);
      expect_ev(0, 16'h0000, 0, 1, 1, 0, 1, "basic_expire");
      expect_ev(0, 16'h0000, 0, 1, 0, 0, 2, "basic_done_drop");
      drv(0, 0, 16'h0, 0, 0, 1);
      drv(0, 0, 16'h0, 0, 0, 1);   // ticks, start and pause in DONE: no change
      drv(0, 0, 16'h0, 1, 0, 1);
      drv(0, 0, 16'h0, 0, 1, 1);
      idle(0, 2);

      // ---- invalid loads from DONE ----
      expect_ev(0, 16'h0000, 0, 1, 0, 1, 1, "bad_0060");
      expect_ev(0, 16'h0000, 0, 1, 0, 0, 2, "bad_0060_drop");
      drv(0, 1, 16'h0060, 0, 0, 0); idle(0, 1);
      expect_ev(0, 16'h0000, 0, 1, 0, 1, 1, "bad_000A");
      expect_ev(0, 16'h0000, 0, 1, 0, 0, 2, "bad_000A_drop");
      drv(0, 1, 16'h000A, 0, 0, 0); idle(0, 1);
      expect_ev(0, 16'h0000, 0, 1, 0, 1, 1, "bad_6000");
      expect_ev(0, 16'h0000, 0, 1, 0, 0, 2, "bad_6000_drop");
      drv(0, 1, 16'h6000, 0, 0, 0); idle(0, 1);

      // ---- borrow chain 10:00 -> 00:00 ----
      expect_ev(0, 16'h1000, 0, 0, 0, 0, 1, "borrow_load");
      drv(0, 1, 16'h1000, 0, 0, 0);
      expect_ev(0, 16'h1000, 1, 0, 0, 0, 1, "borrow_start");
      drv(0, 0, 16'h0, 1, 0, 0);
      expect_ev(0, 16'h0959, 1, 0, 0, 0, 1, "borrow_first");
      drv(0, 0, 16'h0, 0, 0, 1);
      for (int i = 1; i <= 599; i++) begin
         int s;
         s = 599 - i;
         if (s > 0) begin
            expect_ev(0, to_bcd(s), 1, 0, 0, 0, 1, "borrow_step");
         end else begin
            expect_ev(0, 16'h0000, 0, 1, 1, 0, 1, "borrow_expire");
            expect_ev(0, 16'h0000, 0, 1, 0, 0, 2, "borrow_done_drop");
         end
         drv(0, 0, 16'h0, 0, 0, 1);
      end
      idle(0, 2);

      // ---- zero load, start ignored ----
      expect_ev(0, 16'h0000, 0, 0, 0, 0, 1, "zero_load");
      drv(0, 1, 16'h0000, 0, 0, 0);
      drv(0, 0, 16'h0, 1, 0, 0);
      drv(0, 0, 16'h0, 0, 0, 1);
      idle(0, 1);

      // ---- max legal load, invalid load in IDLE ----
      expect_ev(0, 16'h5959, 0, 0, 0, 0, 1, "max_load");
      drv(0, 1, 16'h5959, 0, 0, 0);
      expect_ev(0, 16'h5959, 0, 0, 0, 1, 1, "bad_00A0");
      expect_ev(0, 16'h5959, 0, 0, 0, 0, 2, "bad_00A0_drop");
      drv(0, 1, 16'h00A0, 0, 0, 0); idle(0, 1);

      // ---- start/pause cycles never step ----
      expect_ev(0, 16'h5959, 1, 0, 0, 0, 1, "start_no_step");
      drv(0, 0, 16'h0, 1, 0, 1);
      expect_ev(0, 16'h5958, 1, 0, 0, 0, 1, "step_5958");
      drv(0, 0, 16'h0, 0, 0, 1);
      expect_ev(0, 16'h5958, 0, 0, 0, 0, 1, "pause_no_step");
      drv(0, 0, 16'h0, 0, 1, 1);
      drv(0, 0, 16'h0, 0, 0, 1);   // paused: tick ignored
      expect_ev(0, 16'h5958, 1, 0, 0, 0, 1, "resume_no_step");
      drv(0, 0, 16'h0, 1, 0, 1);
      expect_ev(0, 16'h5957, 1, 0, 0, 0, 1, "step_5957");
      drv(0, 0, 16'h0, 0, 0, 1);

      // ---- load during RUN aborts, no done ----
      expect_ev(0, 16'h0005, 0, 0, 0, 0, 1, "load_abort");
      drv(0, 1, 16'h0005, 0, 0, 0);
      drv(0, 0, 16'h0, 0, 0, 1);
      idle(0, 1);

      // ---- reset mid-RUN ----
      expect_ev(0, 16'h0005, 1, 0, 0, 0, 1, "pre_reset_start");
      drv(0, 0, 16'h0, 1, 0, 0);
      expect_ev(0, 16'h0004, 1, 0, 0, 0, 1, "pre_reset_step");
      drv(0, 0, 16'h0, 0, 0, 1);
      expect_ev(0, 16'h0000, 0, 0, 0, 0, 1, "mid_run_reset");
      rst[0] = 1'b1;
      repeat (2) @(posedge clock);
      #1 rst[0] = 1'b0;
      idle(0, 2);

      // ---- prescale and pause, dut1 (PRESCALE=4) ----
      expect_ev(1, 16'h0010, 0, 0, 0, 0, 1, "ps_load");
      drv(1, 1, 16'h0010, 0, 0, 0);
      expect_ev(1, 16'h0010, 1, 0, 0, 0, 1, "ps_start");
      drv(1, 0, 16'h0, 1, 0, 0);
      drv(1, 0, 16'h0, 0, 0, 1);
      drv(1, 0, 16'h0, 0, 0, 1);
      expect_ev(1, 16'h0010, 0, 0, 0, 0, 1, "ps_pause");
      drv(1, 0, 16'h0, 0, 1, 0);
      for (int i = 0; i < 5; i++) drv(1, 0, 16'h0, 0, 0, 1);
      expect_ev(1, 16'h0010, 1, 0, 0, 0, 1, "ps_resume");
      drv(1, 0, 16'h0, 1, 0, 0);
      expect_ev(1, 16'h0009, 1, 0, 0, 0, 2, "ps_step_0009");
      drv(1, 0, 16'h0, 0, 0, 1);
      drv(1, 0, 16'h0, 0, 0, 1);
      expect_ev(1, 16'h0009, 0, 0, 0, 0, 1, "ps_start_pause");
      drv(1, 0, 16'h0, 1, 1, 0);
      expect_ev(1, 16'h0009, 1, 0, 0, 0, 1, "ps_resume2");
      drv(1, 0, 16'h0, 1, 0, 0);
      expect_ev(1, 16'h0008, 1, 0, 0, 0, 4, "ps_step_0008");
      for (int i = 0; i < 4; i++) drv(1, 0, 16'h0, 0, 0, 1);
      idle(1, 2);

      // ---- auto-reload, dut2 ----
      expect_ev(2, 16'h0002, 0, 0, 0, 0, 1, "rl_load");
      drv(2, 1, 16'h0002, 0, 0, 0);
      expect_ev(2, 16'h0002, 1, 0, 0, 0, 1, "rl_start");
      drv(2, 0, 16'h0, 1, 0, 0);
      for (int t = 1; t <= 6; t++) begin
         if (t % 2 == 1) expect_ev(2, 16'h0001, 1, 0, 0, 0, 1, "rl_odd_tick");
         else            expect_ev(2, 16'h0002, 1, 0, 1, 0, 1, "rl_reload_tick");
         drv(2, 0, 16'h0, 0, 0, 1);
      end
      expect_ev(2, 16'h0002, 1, 0, 0, 0, 1, "rl_done_drop");
      idle(2, 3);

      // Everything queued must have been observed.
      compared++;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL missing_events: %0d left in queue, want 0 (next %s)", q.size(), q[0].name);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
